panel_input_ctrl: RTL
=====================

# panel_input_ctrl

Parametrised front-panel input controller for the oscilloscope: N quadrature encoders (volts/div, time/div, trigger level, …) and M push keys (save, read, stop, single, coupling, edge). Every pin is synchronised and glitch-filtered; encoders become saturating position counters with a software preload port; keys become level, press-pulse and toggle flags. An optional decoder drives the two analog front-end gain relays from encoder 0/1 positions. Sits between the panel pins and the acquisition/display control logic.

## Interface
Parameters:
- N_ENC, 4: number of quadrature encoders (≥2 when relay decode compiled in)
- CNT_W, 4: encoder count width
- ENC_MAX, 15: upper saturation limit for all counters (≤2^CNT_W−1)
- ENC_FILT, 2: encoder pin filter length, cycles (≥1)
- N_KEY, 7: number of keys
- DEB_CYC, 4: key debounce length, cycles (≥1)
- TOG_INIT, 7'b0110000: reset value of each key_tog bit

Ports (one clock; reset is asynchronous and active-low):
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- enc_a  in  N_ENC  encoder A pins, asynchronous
- enc_b  in  N_ENC  encoder B pins, asynchronous
- key_in  in  N_KEY  key pins, active-high, asynchronous
- ld_en  in  1  preload strobe, one cycle
- ld_idx  in  clog2(N_ENC)  encoder to preload
- ld_val  in  CNT_W  preload value
- enc_num  out  N_ENC*CNT_W  packed counters, encoder i at [i*CNT_W +: CNT_W]
- enc_evt  out  N_ENC  one-cycle pulse whenever counter i changes value
- key_lvl  out  N_KEY  debounced key levels
- key_pulse  out  N_KEY  one-cycle press pulse
- key_tog  out  N_KEY  toggles on every press
- relay_ad1  out  2  channel-1 gain relay
- relay_ad2  out  2  channel-2 gain relay

## Operation
- Reset: all sync/filter state 0, enc_num 0, enc_evt/key_lvl/key_pulse 0, key_tog = TOG_INIT, relays 2'b11.
- Every pin: 2-FF synchroniser, then a filter holding a registered level; a counter runs while synchronised ≠ filtered and clears on match; when it reaches length−1 with mismatch still present, filtered level takes the new value.
- Encoder step: on filtered-A rise, filtered-B 0 → +1, filtered-B 1 → −1. Saturate: +1 at ENC_MAX and −1 at 0 hold value, no enc_evt.
- Preload: ld_en writes min(ld_val, ENC_MAX) to encoder ld_idx; wins over a same-cycle step on that encoder; enc_evt pulses only if value changes. ld_idx ≥ N_ENC ignored.
- Keys: key_lvl = filtered level; filtered rise → key_pulse for one cycle and key_tog inverts. Release produces nothing.
- Reset assertion mid-debounce or mid-step aborts it; no pulse or count produced after release.

## Timing
- Pin level first sampled at edge t: filtered level, enc_num, enc_evt, key_lvl, key_pulse, key_tog all update at edge t+1+FILT (FILT = ENC_FILT or DEB_CYC).
- Glitches shorter than FILT cycles at the synchroniser output are rejected.
- Preload: enc_num updated at the edge sampling ld_en.
- Relays register enc_num: update one edge after the counter.
- Minimum resolvable encoder edge spacing: FILT+1 cycles.

## Configuration
- PANEL_RELAY_DECODE_EN defined: relay_ad1/relay_ad2 decode counter 0/1: value 0–3 → 2'b11, 4–5 → 2'b01, 6–8 → 2'b10, ≥9 → 2'b00.
- Not defined: relay outputs tied to 2'b11, no decode logic; N_ENC≥2 not required.

## Test plan
Defaults, macro defined.
- Reset with key_in=0 → enc_num 0, relays 2'b11, key_tog 7'b0110000, all pulses 0.
- Encoder 0: 5 A-rises with B=0, edges ≥8 cycles apart → enc_num[3:0]=5, 5 enc_evt pulses, relay_ad1 2'b01 one cycle after reaching 4.
- Encoder 1 at 0, A-rise with B=1 → stays 0, no enc_evt; 20 rises with B=0 → saturates 15, relay_ad2 2'b00.
- key_in[0] 3-cycle glitch → no change; 10-cycle press → key_pulse[0] one cycle at t+5, key_tog[0] 0→1, key_lvl[0] high.
- ld_en idx=2 val=9 same cycle as encoder-2 step → enc_num[11:8]=9; ld_val=14 with ENC_MAX=12 → 12.
- sys_rst_n low mid-debounce of key 3 → key_tog restored to TOG_INIT, no pulse after release.

Source files
------------

// File: rtl/panel_input_ctrl.sv
// Front-panel input controller: synchronised, glitch-filtered quadrature encoders and keys.
// Encoder 0/1 gain-relay decode is compiled in when PANEL_RELAY_DECODE_EN is defined.

module panel_pin_filter #(
    parameter int FILT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic lvl,
    output logic upd
);
    localparam int CW = $clog2(FILT) + 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          mis;

    assign mis = sync[1] ^ lvl;
    // upd marks the edge at which lvl takes the synchronised value
    assign upd = mis && (cnt == CW'(FILT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
            lvl  <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            if (!mis || upd) cnt <= '0;
            else             cnt <= cnt + CW'(1);
            if (upd) lvl <= sync[1];
        end
    end
endmodule

module panel_enc_lane #(
    parameter int CNT_W    = 4,
    parameter int ENC_MAX  = 15,
    parameter int ENC_FILT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             ld_hit,
    input  logic [CNT_W-1:0] ld_val,
    output logic [CNT_W-1:0] cnt,
    output logic             evt
);
    localparam logic [CNT_W-1:0] MAXV = CNT_W'(ENC_MAX);

    logic             a_lvl, a_upd, b_lvl, b_upd;
    logic             a_rise, b_now;
    logic [CNT_W-1:0] nxt;

    panel_pin_filter #(.FILT(ENC_FILT)) u_fa (
        .clk(clk), .rst_n(rst_n), .pin(a), .lvl(a_lvl), .upd(a_upd)
    );
    panel_pin_filter #(.FILT(ENC_FILT)) u_fb (
        .clk(clk), .rst_n(rst_n), .pin(b), .lvl(b_lvl), .upd(b_upd)
    );

    assign a_rise = a_upd & ~a_lvl;
    // direction uses B as it stands after this edge
    assign b_now  = b_upd ? ~b_lvl : b_lvl;

    always_comb begin
        nxt = cnt;
        if (ld_hit) begin
            nxt = (ld_val > MAXV) ? MAXV : ld_val;
        end else if (a_rise) begin
            if (!b_now && cnt != MAXV)     nxt = cnt + CNT_W'(1);
            else if (b_now && cnt != '0)   nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            evt <= 1'b0;
        end else begin
            cnt <= nxt;
            evt <= (nxt != cnt);
        end
    end
endmodule

module panel_key_lane #(
    parameter int   DEB_CYC = 4,
    parameter logic TOG_RST = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic lvl,
    output logic pulse,
    output logic tog
);
    logic upd, press;

    panel_pin_filter #(.FILT(DEB_CYC)) u_f (
        .clk(clk), .rst_n(rst_n), .pin(pin), .lvl(lvl), .upd(upd)
    );

    assign press = upd & ~lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse <= 1'b0;
            tog   <= TOG_RST;
        end else begin
            pulse <= press;
            if (press) tog <= ~tog;
        end
    end
endmodule

module panel_input_ctrl #(
    parameter int              N_ENC    = 4,
    parameter int              CNT_W    = 4,
    parameter int              ENC_MAX  = 15,
    parameter int              ENC_FILT = 2,
    parameter int              N_KEY    = 7,
    parameter int              DEB_CYC  = 4,
    parameter logic [N_KEY-1:0] TOG_INIT = 7'b0110000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [N_ENC-1:0]         enc_a,
    input  logic [N_ENC-1:0]         enc_b,
    input  logic [N_KEY-1:0]         key_in,
    input  logic                     ld_en,
    input  logic [$clog2(N_ENC)-1:0] ld_idx,
    input  logic [CNT_W-1:0]         ld_val,
    output logic [N_ENC*CNT_W-1:0]   enc_num,
    output logic [N_ENC-1:0]         enc_evt,
    output logic [N_KEY-1:0]         key_lvl,
    output logic [N_KEY-1:0]         key_pulse,
    output logic [N_KEY-1:0]         key_tog,
    output logic [1:0]               relay_ad1,
    output logic [1:0]               relay_ad2
);
    localparam int IDX_W = $clog2(N_ENC);

    logic [N_ENC-1:0][CNT_W-1:0] cnt;

    generate
        for (genvar i = 0; i < N_ENC; i++) begin : g_enc
            panel_enc_lane #(
                .CNT_W(CNT_W), .ENC_MAX(ENC_MAX), .ENC_FILT(ENC_FILT)
            ) u_lane (
                .clk    (sys_clk),
                .rst_n  (sys_rst_n),
                .a      (enc_a[i]),
                .b      (enc_b[i]),
                .ld_hit (ld_en && (ld_idx == IDX_W'(i))),
                .ld_val (ld_val),
                .cnt    (cnt[i]),
                .evt    (enc_evt[i])
            );
        end

        for (genvar k = 0; k < N_KEY; k++) begin : g_key
            panel_key_lane #(
                .DEB_CYC(DEB_CYC), .TOG_RST(TOG_INIT[k])
            ) u_lane (
                .clk   (sys_clk),
                .rst_n (sys_rst_n),
                .pin   (key_in[k]),
                .lvl   (key_lvl[k]),
                .pulse (key_pulse[k]),
                .tog   (key_tog[k])
            );
        end
    endgenerate

    assign enc_num = cnt;

`ifdef PANEL_RELAY_DECODE_EN
    function automatic logic [1:0] relay_dec(input logic [CNT_W-1:0] v);
        int unsigned u;
        u = 32'(v);
        if (u <= 3) return 2'b11;
        if (u <= 5) return 2'b01;
        if (u <= 8) return 2'b10;
        return 2'b00;
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            relay_ad1 <= 2'b11;
            relay_ad2 <= 2'b11;
        end else begin
            relay_ad1 <= relay_dec(cnt[0]);
            relay_ad2 <= relay_dec(cnt[1]);
        end
    end
`else
    assign relay_ad1 = 2'b11;
    assign relay_ad2 = 2'b11;
`endif
endmodule
